div_seq_radix2: RTL and testbench

- Sequential radix-2 restoring divider for the EX stage. It produces the 64-bit {remainder, quotient} that the ALU selects for DIV/DIVU and forwards to HI/LO.
- Computes one quotient bit per cycle over an accept/compute/hold handshake, so the ALU can stall EX until the result is available.
- Replaces the current divider instance behind the same operand and handshake contract, with an explicit pipeline flush input.

---
 rtl/div_seq_radix2_if.sv | 34 +++
 rtl/div_seq_radix2.sv | 153 +++++++++++++++
 tb/tb_div_seq_radix2.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_radix2_if.sv
// div_seq_radix2_if
//   Operand/result handshake bundle between the EX-stage ALU (master)
//   and the sequential divider (slave).
//   flush     : synchronous cancel of any divide in flight
//   a, b      : dividend / divisor, sampled only when a request is accepted
//   sign      : 1 = signed (DIV), 0 = unsigned (DIVU)
//   opn_valid : divide request present in EX
//   res_ready : consumer takes the result this cycle
//   res_valid : result register holds a fresh result
//   busy      : divider iterating
//   result    : {remainder, quotient}
interface div_seq_radix2_if #(
  parameter int WIDTH = 32
);
  logic                 flush;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sign;
  logic                 opn_valid;
  logic                 res_ready;
  logic                 res_valid;
  logic                 busy;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output flush, a, b, sign, opn_valid, res_ready,
    input  res_valid, busy, result
  );

  modport slave (
    input  flush, a, b, sign, opn_valid, res_ready,
    output res_valid, busy, result
  );
endinterface

// File: rtl/div_seq_radix2.sv
// div_seq_radix2
//   Sequential radix-2 restoring divider producing {remainder, quotient}.
//   One quotient bit per cycle on magnitudes, followed by one fix-up cycle
//   that applies the signs (or the divide-by-zero pattern) and registers
//   the result. res_valid rises 33 edges after the accepting edge.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_seq_radix2_if.slave (flush, a, b, sign, opn_valid,
//          res_ready in; res_valid, busy, result out, all registered)
module div_seq_radix2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  div_seq_radix2_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value seen on the fix-up cycle, i.e. after the last iteration
  // (counter == WIDTH-1) has completed.
  localparam logic [CNT_W-1:0] FIX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_b_abs;
  logic [WIDTH-1:0]     r_a_raw;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_b_zero;
  logic                 r_res_valid;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic [WIDTH-1:0]     w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [2*WIDTH-1:0]   w_result_fix;

  // Operand magnitudes: only a signed request treats the MSB as a sign.
  assign w_a_neg = bus.sign & bus.a[WIDTH-1];
  assign w_b_neg = bus.sign & bus.b[WIDTH-1];
  assign w_a_abs = w_a_neg ? (-bus.a) : bus.a;
  assign w_b_abs = w_b_neg ? (-bus.b) : bus.b;

  // One restoring step. The bit shifted out of the partial remainder is
  // kept as the trial MSB: when it is set the shifted remainder is at
  // least 2^WIDTH and the subtraction always succeeds, which matters for
  // divisors with the top bit set.
  assign w_rem_sh  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_trial   = {r_rem[WIDTH-1], w_rem_sh} - {1'b0, r_b_abs};
  assign w_rem_nxt = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  // Sign fix-up. Quotient negation wraps naturally, so the most-negative
  // dividend over -1 returns the dividend without any trap.
  assign w_quo_fix    = r_neg_q ? (-r_quo) : r_quo;
  assign w_rem_fix    = r_neg_r ? (-r_rem) : r_rem;
  assign w_result_fix = r_b_zero ? {r_a_raw, {WIDTH{1'b1}}}
                                 : {w_rem_fix, w_quo_fix};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_b_abs     <= {WIDTH{1'b0}};
      r_a_raw     <= {WIDTH{1'b0}};
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= {2*WIDTH{1'b0}};
    end else if (bus.flush) begin
      // Flush beats accept and the result handshake.
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.opn_valid) begin
            r_a_raw  <= bus.a;
            r_b_abs  <= w_b_abs;
            r_neg_q  <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_a_neg;
            r_b_zero <= (bus.b == {WIDTH{1'b0}});
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= w_a_abs;
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= ST_BUSY;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (r_cnt == FIX_CNT) begin
            r_result    <= w_result_fix;
            r_res_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_state     <= ST_DONE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          // A request in the handshake cycle waits for the next IDLE cycle.
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= {CNT_W{1'b0}};
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;

endmodule

// File: tb/tb_div_seq_radix2.sv
module tb_div_seq_radix2;

  typedef struct {
    logic [63:0] res;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  div_seq_radix2_if #(.WIDTH(32)) bus_if ();

  div_seq_radix2 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request from posedge+1; returns at posedge+1 after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit push, input bit keep);
    exp_t e;
    bus_if.a         = a;
    bus_if.b         = b;
    bus_if.sign      = s;
    bus_if.opn_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.res = exp;
      e.acc = cyc;
      sb_q.push_back(e);
    end
    if (!keep) bus_if.opn_valid = 1'b0;
    chk("busy_after_accept", 64'(bus_if.busy), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus_if.res_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(n < 60), 64'd1);
  endtask

  task automatic handshake();
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    chk("valid_drop", 64'(bus_if.res_valid), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp);
    start_op(a, b, s, exp, 1'b1, 1'b0);
    wait_valid("timeout");
    handshake();
  endtask

  // Monitor: each rising res_valid consumes one expectation.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.res_valid === 1'b1 && !prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 64'(bus_if.res_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", bus_if.result, e.res);
          chk("latency", 64'(cyc - e.acc), 64'd33);
        end
      end
      prev = (bus_if.res_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b0;
    bus_if.flush     = 1'b0;
    bus_if.a         = 32'd0;
    bus_if.b         = 32'd0;
    bus_if.sign      = 1'b0;
    bus_if.opn_valid = 1'b0;
    bus_if.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  64'(bus_if.res_valid), 64'd0);
    chk("rst_busy",   64'(bus_if.busy),      64'd0);
    chk("rst_result", bus_if.result,         64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned 100/7 with a held result.
    start_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b1, 1'b0);
    wait_valid("timeout_100_7");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", bus_if.result, {32'h0000_0002, 32'h0000_000E});
      chk("hold_valid",  64'(bus_if.res_valid), 64'd1);
    end
    handshake();

    // Signed sign matrix.
    run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h0000_0003});

    // Extremes.
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000});
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF});

    // Divide by zero.
    run_op(32'h1234_5678, 32'h0000_0000, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF});

    // Flush at iteration 10, then 9/3 on the following cycle.
    start_op(32'd1000, 32'd3, 1'b0, 64'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus_if.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_if.flush = 1'b0;
    chk("flush_busy",  64'(bus_if.busy),      64'd0);
    chk("flush_valid", 64'(bus_if.res_valid), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, {32'h0000_0000, 32'h0000_0003});

    // Async reset at iteration 20, then 50/5.
    start_op(32'd1000, 32'd3, 1'b0, 64'd0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy",   64'(bus_if.busy),      64'd0);
    chk("arst_valid",  64'(bus_if.res_valid), 64'd0);
    chk("arst_result", bus_if.result,         64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd50, 32'd5, 1'b0, {32'h0000_0000, 32'h0000_000A});

    // Back-to-back with opn_valid held; operands change after accept.
    start_op(32'd20, 32'd6, 1'b0, {32'h0000_0002, 32'h0000_0003}, 1'b1, 1'b1);
    bus_if.a = 32'd81;
    bus_if.b = 32'd9;
    wait_valid("timeout_b2b_a");
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    chk("b2b_valid_drop", 64'(bus_if.res_valid), 64'd0);
    chk("b2b_not_busy",   64'(bus_if.busy),      64'd0);
    begin
      exp_t e;
      e.res = {32'h0000_0000, 32'h0000_0009};
      e.acc = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_if.opn_valid = 1'b0;
    chk("b2b_busy", 64'(bus_if.busy), 64'd1);
    wait_valid("timeout_b2b_b");
    handshake();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
